cr16_regfile_wb_arbiter: RTL and testbench
==========================================

Name: cr16_regfile_wb_arbiter

Overview:
- Write-back arbiter and sequencer for the CR16 register file write port.
- Shares the single 16-bit register bus and its one-hot register enable between two write-back sources: the ALU result path and the memory-load path.
- Uses round-robin arbitration over a valid/ready handshake.
- After reset, sweeps zeros into all 16 registers before accepting traffic. Also counts arbitration conflicts for debug.

Parameters:
- NUM_REGS, 16, number of registers; width of the one-hot enable; must be 16.
- DATA_WIDTH, 16, register data width.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- I_CLK  in  1  system clock; all state updates on rising edge.
- I_NRESET  in  1  asynchronous, active-low reset.
- I_ALU_VALID  in  1  ALU write-back request.
- I_ALU_ADDR  in  4  ALU destination register index.
- I_ALU_DATA  in  16  ALU write data.
- O_ALU_READY  out  1  ALU request accepted this cycle.
- I_MEM_VALID  in  1  load write-back request.
- I_MEM_ADDR  in  4  load destination register index.
- I_MEM_DATA  in  16  load write data.
- O_MEM_READY  out  1  load request accepted this cycle.
- O_REG_BUS  out  16  data driven to the register file bus.
- O_REG_ENABLE  out  16  one-hot register write enable to the register file.
- O_INIT_DONE  out  1  high once the init sweep is complete.
- O_CONFLICT_CNT  out  CNT_WIDTH  cycles in RUN with both requests valid; saturates.

Behaviour:
- Reset (async, I_NRESET=0):
  - O_REG_BUS=0, O_REG_ENABLE=0, O_INIT_DONE=0, O_CONFLICT_CNT=0.
  - RR pointer = ALU-priority.
  - State = INIT, sweep index = 0.
  - Reset mid-sweep or mid-RUN aborts everything; no partial write survives in arbiter state.
- State INIT:
  - Each cycle registers O_REG_BUS=0 and O_REG_ENABLE=1<<idx, then idx++.
  - Enables for r0..r15 appear on 16 consecutive cycles.
  - After idx=15 is issued, go to RUN.
  - O_INIT_DONE rises the cycle after the r15 enable cycle, i.e. 17 cycles after reset release, registered.
  - Both READY outputs are 0 in INIT.
- State RUN:
  - READY outputs are combinational from VALIDs and the RR pointer.
  - Only one valid: that source gets READY=1.
  - Both valid: the source not granted last gets READY=1; the other gets 0. Pointer records the granted source.
  - Neither valid: both READY=0, pointer unchanged.
  - Handshake = VALID & READY at a rising edge.
- Write timing:
  - On a handshake at edge N, the arbiter registers O_REG_BUS=DATA and O_REG_ENABLE=1<<ADDR. Both are visible from edge N until edge N+1; the register file captures at edge N+1.
  - Enable is exactly one cycle per handshake, otherwise all-zero.
  - O_REG_BUS holds its last value when idle.
  - Back-to-back handshakes give back-to-back one-hot enables; sustained throughput is one write per cycle.
- Requester rules:
  - A requester holds VALID, ADDR and DATA stable until its handshake.
  - VALID must not depend on READY.
- Same address from both sources in one cycle: both writes occur on successive cycles, ordered by RR. The later write wins.
- O_CONFLICT_CNT increments in RUN on each cycle with both VALIDs high and saturates at all-ones. It does not count in INIT.
- O_REG_ENABLE is never multi-hot.

Optional Feature:
- Macro: CR16_WB_INIT_SWEEP_EN.
- Defined: INIT state and zero sweep exist exactly as above.
- Undefined:
  - Reset goes straight to RUN.
  - O_INIT_DONE=1 from the first edge after reset release (0 while in reset).
  - No sweep writes are issued; register contents after reset are whatever the register file holds.

Test Plan:
- Init sweep: release reset, both VALIDs 0 -> O_REG_ENABLE = 0x0001, 0x0002, … 0x8000 on 16 consecutive cycles with O_REG_BUS=0; O_INIT_DONE=1 on cycle 17; READYs 0 throughout.
- Single source: after init, ALU VALID with ADDR=5, DATA=0xBEEF for one handshake -> next cycle O_REG_ENABLE=0x0020, O_REG_BUS=0xBEEF; following cycle enable=0; register file r5=0xBEEF.
- Contention: both VALID continuously, ALU ADDR=3 DATA=0x1111, MEM ADDR=3 DATA=0x2222, pointer at ALU-priority:
  - grant order is ALU, MEM;
  - enables 0x0008 with 0x1111, then 0x0008 with 0x2222;
  - r3 ends 0x2222;
  - O_CONFLICT_CNT=1 after the first cycle and 2 after the second. It then stops counting because MEM is no longer valid on the third cycle.
- Streaming fairness: both VALID for 8 cycles, distinct addrs -> grants alternate strictly (4 each); enable never multi-hot; throughput 1 write/cycle.
- Reset mid-sweep: assert I_NRESET=0 during idx=7 -> outputs zero immediately; on release the sweep restarts at r0.
- Macro off: compile without CR16_WB_INIT_SWEEP_EN, MEM VALID ADDR=15 DATA=0xFFFF right after reset -> READY on the first cycle; enable 0x8000 the next cycle; no sweep enables seen.

Source files
------------

// File: rtl/cr16_regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the CR16 register file write port (ALU vs. load path).
// Define CR16_WB_INIT_SWEEP_EN to zero all registers after reset before traffic is accepted.
module cr16_regfile_wb_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic                  I_ALU_VALID,
    input  logic [3:0]            I_ALU_ADDR,
    input  logic [DATA_WIDTH-1:0] I_ALU_DATA,
    output logic                  O_ALU_READY,
    input  logic                  I_MEM_VALID,
    input  logic [3:0]            I_MEM_ADDR,
    input  logic [DATA_WIDTH-1:0] I_MEM_DATA,
    output logic                  O_MEM_READY,
    output logic [DATA_WIDTH-1:0] O_REG_BUS,
    output logic [NUM_REGS-1:0]   O_REG_ENABLE,
    output logic                  O_INIT_DONE,
    output logic [CNT_WIDTH-1:0]  O_CONFLICT_CNT
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef CR16_WB_INIT_SWEEP_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic                  mem_prio_q, mem_prio_d;  // 1: load path wins the next contention
    logic [DATA_WIDTH-1:0] reg_bus_q, reg_bus_d;
    logic [NUM_REGS-1:0]   reg_en_q, reg_en_d;
    logic                  init_done_q, init_done_d;
    logic [CNT_WIDTH-1:0]  conflict_cnt_q, conflict_cnt_d;
    logic                  alu_grant, mem_grant, both_valid;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        both_valid     = I_ALU_VALID & I_MEM_VALID;
        alu_grant      = 1'b0;
        mem_grant      = 1'b0;
        state_d        = state_q;
        idx_d          = idx_q;
        mem_prio_d     = mem_prio_q;
        reg_bus_d      = reg_bus_q;
        reg_en_d       = '0;
        init_done_d    = (state_q == ST_RUN);
        conflict_cnt_d = conflict_cnt_q;

        case (state_q)
            ST_INIT: begin
                reg_bus_d = '0;
                reg_en_d  = onehot(idx_q);
                idx_d     = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                alu_grant = I_ALU_VALID & (~I_MEM_VALID | ~mem_prio_q);
                mem_grant = I_MEM_VALID & ~alu_grant;
                if (both_valid) begin
                    conflict_cnt_d = sat_inc(conflict_cnt_q);
                end
                if (alu_grant) begin
                    reg_bus_d  = I_ALU_DATA;
                    reg_en_d   = onehot(I_ALU_ADDR);
                    mem_prio_d = 1'b1;
                end else if (mem_grant) begin
                    reg_bus_d  = I_MEM_DATA;
                    reg_en_d   = onehot(I_MEM_ADDR);
                    mem_prio_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q        <= RESET_STATE;
            idx_q          <= 4'd0;
            mem_prio_q     <= 1'b0;
            reg_bus_q      <= '0;
            reg_en_q       <= '0;
            init_done_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mem_prio_q     <= mem_prio_d;
            reg_bus_q      <= reg_bus_d;
            reg_en_q       <= reg_en_d;
            init_done_q    <= init_done_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign O_ALU_READY    = alu_grant;
    assign O_MEM_READY    = mem_grant;
    assign O_REG_BUS      = reg_bus_q;
    assign O_REG_ENABLE   = reg_en_q;
    assign O_INIT_DONE    = init_done_q;
    assign O_CONFLICT_CNT = conflict_cnt_q;
endmodule

// File: tb/tb_cr16_regfile_wb_arbiter.sv
// Scoreboard bench for cr16_regfile_wb_arbiter; follows CR16_WB_INIT_SWEEP_EN like the design.
`timescale 1ns/1ps
module tb_cr16_regfile_wb_arbiter;
`ifdef CR16_WB_INIT_SWEEP_EN
    localparam int SWEEP_START = 0;
`else
    localparam int SWEEP_START = 16;
`endif

    typedef struct packed { logic [3:0] addr; logic [15:0] data; } req_t;
    typedef struct packed { logic [15:0] en; logic [15:0] data; } wr_t;

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b1;
    logic        I_ALU_VALID = 1'b0, I_MEM_VALID = 1'b0;
    logic [3:0]  I_ALU_ADDR = 4'd0, I_MEM_ADDR = 4'd0;
    logic [15:0] I_ALU_DATA = 16'd0, I_MEM_DATA = 16'd0;
    logic        O_ALU_READY, O_MEM_READY, O_INIT_DONE;
    logic [15:0] O_REG_BUS, O_REG_ENABLE, O_CONFLICT_CNT;

    cr16_regfile_wb_arbiter #(.NUM_REGS(16), .DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .I_CLK(I_CLK), .I_NRESET(I_NRESET),
        .I_ALU_VALID(I_ALU_VALID), .I_ALU_ADDR(I_ALU_ADDR), .I_ALU_DATA(I_ALU_DATA),
        .O_ALU_READY(O_ALU_READY),
        .I_MEM_VALID(I_MEM_VALID), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_DATA(I_MEM_DATA),
        .O_MEM_READY(O_MEM_READY),
        .O_REG_BUS(O_REG_BUS), .O_REG_ENABLE(O_REG_ENABLE),
        .O_INIT_DONE(O_INIT_DONE), .O_CONFLICT_CNT(O_CONFLICT_CNT)
    );

    initial forever #5 I_CLK = ~I_CLK;

    req_t        alu_q[$], mem_q[$];
    wr_t         exp_q[$];
    int          sweep_cnt = SWEEP_START;
    bit          alu_last = 1'b0;   // reference: ALU was the most recent grant
    bit          done_exp = 1'b0;
    logic [15:0] cnt_exp = 16'd0;
    logic [15:0] exp_bus = 16'd0;
    logic [15:0] one16 = 16'h0001;
    logic [15:0] rf[16];
    int          wr_seen = 0;
    int          checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: a lone requester wins; on contention the one not granted last wins.
    function automatic bit pick_alu(input bit av, input bit mv);
        if (av && mv) return !alu_last;
        return av;
    endfunction

    // Reference model: advances on each rising edge from the driven inputs.
    initial begin : model
        req_t r;
        wr_t  w;
        forever begin
            @(posedge I_CLK);
            if (!I_NRESET) begin
                sweep_cnt = SWEEP_START;
                alu_last  = 1'b0;
                cnt_exp   = 16'd0;
                done_exp  = 1'b0;
                exp_q.delete();
            end else if (sweep_cnt < 16) begin
                w.en   = one16 << sweep_cnt;
                w.data = 16'h0000;
                exp_q.push_back(w);
                sweep_cnt++;
            end else begin
                done_exp = 1'b1;
                if (I_ALU_VALID && I_MEM_VALID && cnt_exp != 16'hFFFF) cnt_exp++;
                if (I_ALU_VALID || I_MEM_VALID) begin
                    if (pick_alu(I_ALU_VALID, I_MEM_VALID)) begin
                        w.en = one16 << I_ALU_ADDR; w.data = I_ALU_DATA;
                        r = alu_q.pop_front();
                        alu_last = 1'b1;
                    end else begin
                        w.en = one16 << I_MEM_ADDR; w.data = I_MEM_DATA;
                        r = mem_q.pop_front();
                        alu_last = 1'b0;
                    end
                    exp_q.push_back(w);
                end
            end
        end
    end

    // Monitor: every cycle's registered outputs are compared against the scoreboard.
    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge I_CLK);
            #1;
            if (!I_NRESET) begin
                exp_bus = 16'h0000;
                check("rst_enable", 32'(O_REG_ENABLE), 32'h0);
                check("rst_bus", 32'(O_REG_BUS), 32'h0);
                check("rst_init_done", 32'(O_INIT_DONE), 32'h0);
                check("rst_conflict_cnt", 32'(O_CONFLICT_CNT), 32'h0);
            end else begin
                check("enable_onehot0", 32'($countones(O_REG_ENABLE) <= 1), 32'h1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_enable", 32'(O_REG_ENABLE), 32'(e.en));
                    check("write_bus", 32'(O_REG_BUS), 32'(e.data));
                    exp_bus = e.data;
                    if (O_REG_ENABLE != 16'h0) wr_seen++;
                end else begin
                    check("idle_enable", 32'(O_REG_ENABLE), 32'h0);
                    check("idle_bus_hold", 32'(O_REG_BUS), 32'(exp_bus));
                end
                check("init_done", 32'(O_INIT_DONE), 32'(done_exp));
                check("conflict_cnt", 32'(O_CONFLICT_CNT), 32'(cnt_exp));
            end
        end
    end

    // Register file stand-in: captures what the arbiter presents before the next rising edge.
    initial begin : regfile
        for (int i = 0; i < 16; i++) rf[i] = 16'hDEAD;
        forever begin
            @(negedge I_CLK);
            if (I_NRESET) begin
                for (int i = 0; i < 16; i++) if (O_REG_ENABLE[i]) rf[i] = O_REG_BUS;
            end
        end
    end

    task automatic drive();
        if (alu_q.size() > 0) begin
            I_ALU_VALID = 1'b1; I_ALU_ADDR = alu_q[0].addr; I_ALU_DATA = alu_q[0].data;
        end else begin
            I_ALU_VALID = 1'b0; I_ALU_ADDR = 4'($urandom); I_ALU_DATA = 16'($urandom);
        end
        if (mem_q.size() > 0) begin
            I_MEM_VALID = 1'b1; I_MEM_ADDR = mem_q[0].addr; I_MEM_DATA = mem_q[0].data;
        end else begin
            I_MEM_VALID = 1'b0; I_MEM_ADDR = 4'($urandom); I_MEM_DATA = 16'($urandom);
        end
    endtask

    task automatic check_ready();
        bit ea, em;
        if (!I_NRESET) return;
        ea = 1'b0; em = 1'b0;
        if (sweep_cnt >= 16 && (I_ALU_VALID || I_MEM_VALID)) begin
            ea = pick_alu(I_ALU_VALID, I_MEM_VALID);
            em = !ea;
        end
        check("alu_ready", 32'(O_ALU_READY), 32'(ea));
        check("mem_ready", 32'(O_MEM_READY), 32'(em));
    endtask

    task automatic tick();
        @(negedge I_CLK);
        drive();
        #2;
        check_ready();
    endtask

    task automatic assert_reset();
        #1;
        I_NRESET = 1'b0;
        I_ALU_VALID = 1'b0; I_MEM_VALID = 1'b0;
        alu_q.delete(); mem_q.delete();
        #1;
        check("async_rst_enable", 32'(O_REG_ENABLE), 32'h0);
        check("async_rst_bus", 32'(O_REG_BUS), 32'h0);
        check("async_rst_done", 32'(O_INIT_DONE), 32'h0);
        repeat (2) @(posedge I_CLK);
    endtask

    task automatic release_reset();
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        drive();
        #2;
        check_ready();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((alu_q.size() > 0 || mem_q.size() > 0 || exp_q.size() > 0 || sweep_cnt < 16)
               && n < maxc) begin
            tick();
            n++;
        end
        check("idle_within_budget", 32'(n < maxc), 32'h1);
        tick();
    endtask

    initial begin : stim
        int c0, w0;
        #1;
        assert_reset();

        // Load write pending at reset release; with no sweep it is accepted on the first cycle.
        mem_q.push_back('{addr: 4'd15, data: 16'hFFFF});
        release_reset();
        check("first_mem_ready", 32'(O_MEM_READY), 32'(SWEEP_START == 16));
        tick();
        check("first_enable", 32'(O_REG_ENABLE), (SWEEP_START == 16) ? 32'h8000 : 32'h0001);
        wait_idle(60);
        check("init_done_after_init", 32'(O_INIT_DONE), 32'h1);
        for (int i = 0; i < 15; i++)
            check($sformatf("rf_after_init_r%0d", i), 32'(rf[i]),
                  (SWEEP_START == 0) ? 32'h0 : 32'hDEAD);
        check("rf_r15", 32'(rf[15]), 32'hFFFF);

        // Single ALU write.
        alu_q.push_back('{addr: 4'd5, data: 16'hBEEF});
        tick();
        tick();
        check("single_enable", 32'(O_REG_ENABLE), 32'h0020);
        check("single_bus", 32'(O_REG_BUS), 32'hBEEF);
        tick();
        check("single_enable_drop", 32'(O_REG_ENABLE), 32'h0);
        check("single_bus_hold", 32'(O_REG_BUS), 32'hBEEF);
        wait_idle(20);
        check("rf_r5", 32'(rf[5]), 32'hBEEF);

        // Reset in the middle of the sweep (mid-run when there is no sweep).
        assert_reset();
        release_reset();
        repeat (8) tick();
        check("sweep_idx7_enable", 32'(O_REG_ENABLE), (SWEEP_START == 0) ? 32'h0080 : 32'h0);
        assert_reset();
        release_reset();
        tick();
        check("restart_enable", 32'(O_REG_ENABLE), (SWEEP_START == 0) ? 32'h0001 : 32'h0);
        wait_idle(60);

        // Contention on one address, ALU holds priority after reset.
        alu_q.push_back('{addr: 4'd3, data: 16'h1111});
        alu_q.push_back('{addr: 4'd4, data: 16'h3333});
        mem_q.push_back('{addr: 4'd3, data: 16'h2222});
        tick();
        check("contend_cnt0", 32'(O_CONFLICT_CNT), 32'd0);
        tick();
        check("contend_cnt1", 32'(O_CONFLICT_CNT), 32'd1);
        check("contend_first_bus", 32'(O_REG_BUS), 32'h1111);
        tick();
        check("contend_cnt2", 32'(O_CONFLICT_CNT), 32'd2);
        check("contend_second_bus", 32'(O_REG_BUS), 32'h2222);
        tick();
        check("contend_cnt_stop", 32'(O_CONFLICT_CNT), 32'd2);
        wait_idle(20);
        check("rf_r3_later_wins", 32'(rf[3]), 32'h2222);
        check("rf_r4", 32'(rf[4]), 32'h3333);

        // Streaming: 8 requests from each source, distinct addresses.
        c0 = int'(O_CONFLICT_CNT);
        w0 = wr_seen;
        for (int i = 0; i < 8; i++) begin
            alu_q.push_back('{addr: 4'(i), data: 16'($urandom)});
            mem_q.push_back('{addr: 4'(i + 8), data: 16'($urandom)});
        end
        repeat (17) tick();
        check("stream_writes", 32'(wr_seen - w0), 32'd16);
        check("stream_conflicts", 32'(int'(O_CONFLICT_CNT) - c0), 32'd15);
        wait_idle(20);

        // Randomized traffic, occasionally targeting the same register from both sides.
        for (int i = 0; i < 400; i++) begin
            if (alu_q.size() == 0 && $urandom_range(0, 2) != 0)
                alu_q.push_back('{addr: 4'($urandom), data: 16'($urandom)});
            if (mem_q.size() == 0 && $urandom_range(0, 2) != 0)
                mem_q.push_back('{addr: 4'($urandom), data: 16'($urandom)});
            if (alu_q.size() > 0 && mem_q.size() > 0 && $urandom_range(0, 7) == 0)
                mem_q[0].addr = alu_q[0].addr;
            tick();
        end
        wait_idle(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
